// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes seen by decode/hazard logic
// and the FSM state values.
package muldiv_unit_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CALC  = 2'b01,
      ST_FIXUP = 2'b10
   } md_state_e;

   function automatic logic md_is_signed(md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage bundle between the pipeline and the mul/div unit: launch, MTHI/MTLO
// writes, busy/done status and the architectural HI/LO values.
interface muldiv_unit_if #(parameter int WIDTH = 32);
   import muldiv_unit_pkg::*;

   logic             start;
   md_op_e           op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             we_hi;
   logic             we_lo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, A, B, we_hi, we_lo, wdata,
                   input  busy, done, hi, lo);
   modport slave  (input  start, op, A, B, we_hi, we_lo, wdata,
                   output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration, purely combinational: shift-add for multiply on {acc, multiplier},
// restoring trial-subtract-shift for divide on {remainder, dividend/quotient}.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] work,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] next_work
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             fits;

   always_comb begin
      sum    = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand} : '0);
      rem_sh = work[2*WIDTH-1:WIDTH-1];
      fits   = (rem_sh >= {1'b0, operand});
      // remainder stays below the divisor, so the difference always fits in WIDTH bits
      diff   = rem_sh[WIDTH-1:0] - operand;
      if (!is_div) begin
         next_work = {sum, work[WIDTH-1:1]};
      end else if (fits) begin
         next_work = {diff, work[WIDTH-2:0], 1'b1};
      end else begin
         next_work = {rem_sh[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit mul/div with HI/LO; start to done is 34 cycles (1 launch, WIDTH steps, 1 fixup).
// No internal queueing: busy is raised from the launch cycle and start/MTHI/MTLO are ignored while busy.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   muldiv_unit_if.slave  md
);

   localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

   md_state_e          state, state_nxt;
   logic [5:0]         count;
   logic               is_div_q;
   logic               neg_res;
   logic               neg_rem;
   logic               div_zero;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] work;
   logic [2*WIDTH-1:0] work_step;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q;

   logic               is_signed;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot, rem;
   logic [WIDTH-1:0]   hi_fix, lo_fix;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div    (is_div_q),
      .work      (work),
      .operand   (b_q),
      .next_work (work_step)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (md.start) state_nxt = ST_CALC;
         ST_CALC:  if (count == LAST_STEP) state_nxt = ST_FIXUP;
         ST_FIXUP: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      is_signed = md_is_signed(md.op);
      a_mag     = (is_signed && md.A[WIDTH-1]) ? -md.A : md.A;
      b_mag     = (is_signed && md.B[WIDTH-1]) ? -md.B : md.B;
      prod      = neg_res ? -work : work;
      quot      = neg_res ? -work[WIDTH-1:0] : work[WIDTH-1:0];
      rem       = neg_rem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         // the remainder path already reproduces the dividend on a zero divisor
         hi_fix = rem;
         lo_fix = div_zero ? '1 : quot;
      end else begin
         hi_fix = prod[2*WIDTH-1:WIDTH];
         lo_fix = prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= '0;
         is_div_q <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         b_q      <= '0;
         work     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state == ST_FIXUP);
         case (state)
            ST_IDLE: begin
               if (md.start) begin
                  count    <= '0;
                  is_div_q <= md.op[1];
                  neg_res  <= is_signed && (md.A[WIDTH-1] ^ md.B[WIDTH-1]);
                  neg_rem  <= is_signed && md.A[WIDTH-1];
                  div_zero <= (md.B == '0);
                  b_q      <= b_mag;
                  work     <= {{WIDTH{1'b0}}, a_mag};
               end else begin
                  if (md.we_hi) hi_q <= md.wdata;
                  if (md.we_lo) lo_q <= md.wdata;
               end
            end
            ST_CALC: begin
               work  <= work_step;
               count <= count + 6'd1;
            end
            ST_FIXUP: begin
               hi_q <= hi_fix;
               lo_q <= lo_fix;
            end
            default: ;
         endcase
      end
   end

   // busy covers the launch cycle too, so a dependent MFHI/MFLO behind the op stalls at once
   assign md.busy = (state != ST_IDLE) || md.start;
   assign md.done = done_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against a plain-arithmetic 64-bit reference model.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   total  = 0;
   int   passes = 0;
   int   fails  = 0;

   muldiv_unit_if md ();
   muldiv_unit dut (.clk(clk), .reset(reset), .md(md));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: returns {hi, lo} from the architectural definition.
   function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      int     qa, qb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qa = $signed(a);
      qb = $signed(b);
      case (op)
         2'd0: return 64'(sa * sb);
         2'd1: return {32'b0, a} * {32'b0, b};
         2'd2: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = qa / qb;
            r = qa % qb;
            return {r, q};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // inj_kind: 0 none, 1 MTLO mid-op, 2 second start mid-op, 3 MTHI+MTLO together with start
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_kind, input int inj_at, input bit watch,
                         output logic [31:0] rhi, output logic [31:0] rlo,
                         output int lat, output int bcnt, output int ndone);
      logic [31:0] lo_before;
      rhi = 'x;
      rlo = 'x;
      @(posedge clk); #1;
      md.start = 1'b1;
      md.op    = md_op_e'(op);
      md.A     = a;
      md.B     = b;
      if (inj_kind == 3) begin
         md.we_hi = 1'b1;
         md.we_lo = 1'b1;
         md.wdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      bcnt      = md.busy ? 1 : 0;
      lat       = 0;
      ndone     = 0;
      lo_before = md.lo;
      @(posedge clk); #1;
      md.start = 1'b0;
      md.we_hi = 1'b0;
      md.we_lo = 1'b0;
      md.A     = $urandom;
      md.B     = $urandom;
      md.op    = md_op_e'($urandom_range(0, 3));
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (md.busy) bcnt++;
         if (inj_kind == 1 && i == inj_at + 2) check("lo frozen while busy", 64'(md.lo), 64'(lo_before));
         if (i == inj_at && inj_kind == 1) begin
            md.we_lo = 1'b1;
            md.wdata = 32'h55;
         end else if (i == inj_at && inj_kind == 2) begin
            md.start = 1'b1;
            md.op    = MD_MULTU;
            md.A     = 32'd3;
            md.B     = 32'd5;
         end else if (i == inj_at + 1) begin
            md.we_lo = 1'b0;
            md.start = 1'b0;
         end
         if (md.done) begin
            ndone++;
            if (lat == 0) begin
               lat = i;
               rhi = md.hi;
               rlo = md.lo;
            end
         end
         if (lat != 0 && (!watch || i >= lat + 40)) break;
      end
   endtask

   task automatic directed(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int inj_kind = 0, input int inj_at = 0);
      logic [31:0] rhi, rlo;
      int          lat, bcnt, ndone;
      run_op(op, a, b, inj_kind, inj_at, inj_kind == 2, rhi, rlo, lat, bcnt, ndone);
      check({tag, " done seen"}, 64'(lat != 0), 64'd1);
      check({tag, " hi"}, 64'(rhi), 64'(exp_hi));
      check({tag, " lo"}, 64'(rlo), 64'(exp_lo));
      if (inj_kind == 2) check({tag, " one done pulse"}, 64'(ndone), 64'd1);
   endtask

   initial begin
      logic [31:0] rhi, rlo, a, b;
      logic [63:0] exp;
      logic [1:0]  op;
      int          lat, bcnt, ndone, seen_done;

      md.start = 1'b0;
      md.op    = MD_MULT;
      md.A     = '0;
      md.B     = '0;
      md.we_hi = 1'b0;
      md.we_lo = 1'b0;
      md.wdata = '0;
      reset    = 1'b1;
      repeat (2) @(negedge clk);
      check("reset hi", 64'(md.hi), 64'd0);
      check("reset lo", 64'(md.lo), 64'd0);
      check("reset busy", 64'(md.busy), 64'd0);
      check("reset done", 64'(md.done), 64'd0);
      reset = 1'b0;

      // latency and busy window
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, rhi, rlo, lat, bcnt, ndone);
      check("multu latency", 64'(lat), 64'd34);
      check("multu busy cycles", 64'(bcnt), 64'd34);
      check("multu hi", 64'(rhi), 64'hFFFF_FFFE);
      check("multu lo", 64'(rlo), 64'h1);

      directed("mult -7*3", 2'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      directed("mult min*min", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
      directed("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      directed("divu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
      directed("divu 5/0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
      directed("div -9/0", 2'd2, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
      directed("div min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      directed("div 7/-2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

      // MTHI, then both writes together
      @(posedge clk); #1;
      md.we_hi = 1'b1;
      md.wdata = 32'h1234;
      @(posedge clk); #1;
      md.we_hi = 1'b0;
      @(negedge clk);
      check("mthi hi", 64'(md.hi), 64'h1234);
      @(posedge clk); #1;
      md.we_hi = 1'b1;
      md.we_lo = 1'b1;
      md.wdata = 32'hA5A5_0F0F;
      @(posedge clk); #1;
      md.we_hi = 1'b0;
      md.we_lo = 1'b0;
      @(negedge clk);
      check("mthi+mtlo hi", 64'(md.hi), 64'hA5A5_0F0F);
      check("mthi+mtlo lo", 64'(md.lo), 64'hA5A5_0F0F);

      directed("mtlo while busy", 2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1, 5);
      directed("second start", 2'd3, 32'd1000, 32'd9, 32'd1, 32'd111, 2, 12);
      directed("start beats mt", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 3, 0);

      // reset while CALC holds count 10
      @(posedge clk); #1;
      md.start = 1'b1;
      md.op    = MD_MULTU;
      md.A     = 32'hFFFF_FFFF;
      md.B     = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      md.start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midop reset hi", 64'(md.hi), 64'd0);
      check("midop reset lo", 64'(md.lo), 64'd0);
      check("midop reset busy", 64'(md.busy), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (md.done || md.busy) seen_done++;
      end
      check("no activity after reset", 64'(seen_done), 64'd0);
      directed("after reset", 2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6);

      // random scoreboard with corner-biased operands
      for (int n = 0; n < 1500; n++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0: a = 32'h0;
            1: a = 32'h8000_0000;
            2: a = 32'hFFFF_FFFF;
            3: a = 32'($urandom_range(0, 20));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         exp = ref_model(op, a, b);
         run_op(op, a, b, 0, 0, 1'b0, rhi, rlo, lat, bcnt, ndone);
         check($sformatf("rand%0d op%0d %h,%h done", n, op, a, b), 64'(lat), 64'd34);
         check($sformatf("rand%0d op%0d %h,%h hi", n, op, a, b), 64'(rhi), 64'(exp[63:32]));
         check($sformatf("rand%0d op%0d %h,%h lo", n, op, a, b), 64'(rlo), 64'(exp[31:0]));
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
